// File: rtl/adder_sched_pkg.sv
// adder_sched_pkg: shared FSM state type, limits and id-width helper
package adder_sched_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  localparam int LAT_MAX = 4;
  localparam int CNT_W = 3;
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/adder_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at ptr, one-hot grant plus index
module rr_arbiter
  import adder_sched_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);
  // scan from the far end down so the candidate closest to ptr is written last and wins
  always_comb begin
    int j;
    j = 0;
    idx = '0;
    any = |req;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NREQ;
      if (req[j]) idx = IDW'(j);
    end
    gnt = '0;
    gnt[idx] = any;
  end
endmodule

// File: rtl/adder_sched.sv
// adder_sched: round-robin scheduler for one shared external adder; ADDER_SCHED_OVF_EN adds rsp_ovf
module adder_sched
  import adder_sched_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int NREQ = 2,
  parameter int LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  input  logic [NREQ-1:0]         req_cin,
  output logic [WIDTH-1:0]        add_a,
  output logic [WIDTH-1:0]        add_b,
  output logic                    add_cin,
  input  logic [WIDTH-1:0]        add_sum,
  input  logic                    add_cout,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [WIDTH-1:0]        rsp_sum,
  output logic                    rsp_cout,
`ifdef ADDER_SCHED_OVF_EN
  output logic                    rsp_ovf,
`endif
  output logic [clog2(NREQ)-1:0]  rsp_id
);
  localparam int IDW = clog2(NREQ);
  state_t state, state_nx;
  logic [IDW-1:0] ptr, win;
  logic [NREQ-1:0] gnt;
  logic any;
  logic [CNT_W-1:0] cnt;
  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req(req_valid),
    .ptr(ptr),
    .gnt(gnt),
    .idx(win),
    .any(any)
  );
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  // next state: accept in IDLE, count down the window in BUSY, hold RESP until consumed
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = any ? BUSY : IDLE;
      BUSY:    state_nx = (cnt == CNT_W'(1)) ? RESP : BUSY;
      RESP:    state_nx = rsp_ready ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  // outputs: grant only while idle, response valid exactly while in RESP
  always_comb begin
    req_ready = (state == IDLE) ? gnt : '0;
    rsp_valid = (state == RESP);
  end
  // datapath: latch winner operands, run the window counter, capture the adder result
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      cnt <= '0;
      add_a <= '0;
      add_b <= '0;
      add_cin <= 1'b0;
      rsp_sum <= '0;
      rsp_cout <= 1'b0;
      rsp_id <= '0;
`ifdef ADDER_SCHED_OVF_EN
      rsp_ovf <= 1'b0;
`endif
    end else if (state == IDLE && any) begin
      add_a <= req_a[win*WIDTH +: WIDTH];
      add_b <= req_b[win*WIDTH +: WIDTH];
      add_cin <= req_cin[win];
      cnt <= CNT_W'(LAT);
      ptr <= (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
      rsp_id <= win;
    end else if (state == BUSY) begin
      cnt <= cnt - 1'b1;
      if (cnt == CNT_W'(1)) begin
        rsp_sum <= add_sum;
        rsp_cout <= add_cout;
`ifdef ADDER_SCHED_OVF_EN
        rsp_ovf <= (add_a[WIDTH-1] == add_b[WIDTH-1]) && (add_sum[WIDTH-1] != add_a[WIDTH-1]);
`endif
      end
    end
  end
endmodule

// File: tb/tb_adder_sched.sv
// tb_adder_sched: directed checks of adder_sched with LAT=1 and LAT=3 instances and a behavioural adder
module tb_adder_sched;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] req_valid, req_ready, req_cin;
  logic [11:0] req_a, req_b;
  logic [5:0] add_a, add_b, add_sum, rsp_sum;
  logic add_cin, add_cout, rsp_valid, rsp_ready, rsp_cout;
  logic [0:0] rsp_id;
  logic [1:0] v3, rdy3, c3;
  logic [11:0] a3, b3;
  logic [5:0] add_a3, add_b3, add_sum3, sum3;
  logic add_cin3, add_cout3, val3, cout3;
  logic [0:0] id3;
`ifdef ADDER_SCHED_OVF_EN
  logic ovf0, ovf3;
`endif
  int cmp = 0;
  int bad = 0;
  always #5 clk = ~clk;
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {6'b0, add_cin};
  assign {add_cout3, add_sum3} = {1'b0, add_a3} + {1'b0, add_b3} + {6'b0, add_cin3};
  adder_sched #(.WIDTH(6), .NREQ(2), .LAT(1)) u0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
`ifdef ADDER_SCHED_OVF_EN
    .rsp_ovf(ovf0),
`endif
    .rsp_id(rsp_id)
  );
  adder_sched #(.WIDTH(6), .NREQ(2), .LAT(3)) u3 (
    .clk(clk), .rst(rst), .req_valid(v3), .req_ready(rdy3),
    .req_a(a3), .req_b(b3), .req_cin(c3),
    .add_a(add_a3), .add_b(add_b3), .add_cin(add_cin3), .add_sum(add_sum3), .add_cout(add_cout3),
    .rsp_valid(val3), .rsp_ready(1'b1), .rsp_sum(sum3), .rsp_cout(cout3),
`ifdef ADDER_SCHED_OVF_EN
    .rsp_ovf(ovf3),
`endif
    .rsp_id(id3)
  );
  task automatic chk(input string tag, input int obs, input int exp);
    cmp++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic put(input int i, input int a, input int b, input int c);
    req_a[i*6 +: 6] = 6'(a);
    req_b[i*6 +: 6] = 6'(b);
    req_cin[i] = c[0];
  endtask
  task automatic txn(input int i, input int a, input int b, input int c, input int es, input int ec);
    put(i, a, b, c);
    req_valid = 2'(1 << i);
    #1 chk("txn_ready", int'(req_ready), 1 << i);
    step;
    req_valid = 2'b00;
    #1 chk("txn_busy_valid", int'(rsp_valid), 0);
    chk("txn_add_a", int'(add_a), a);
    step;
    #1 chk("txn_rsp_valid", int'(rsp_valid), 1);
    chk("txn_sum", int'(rsp_sum), es);
    chk("txn_cout", int'(rsp_cout), ec);
    chk("txn_id", int'(rsp_id), i);
    step;
  endtask
  initial begin
    rst = 1'b1;
    rsp_ready = 1'b1;
    req_valid = '0; req_a = '0; req_b = '0; req_cin = '0;
    v3 = '0; a3 = '0; b3 = '0; c3 = '0;
    repeat (2) step;
    rst = 1'b0;
    #1 chk("rst_valid", int'(rsp_valid), 0);
    chk("rst_ready", int'(req_ready), 0);
    chk("rst_add_a", int'(add_a), 0);
    chk("rst_sum", int'(rsp_sum), 0);
    chk("rst_id", int'(rsp_id), 0);
    step;
    chk("idle_no_req_ready", int'(req_ready), 0);
    txn(0, 5, 3, 0, 8, 0);
    txn(0, 63, 1, 0, 0, 1);
    txn(1, 63, 63, 1, 63, 1);
    chk("idle_hold_add_a", int'(add_a), 63);
    rst = 1'b1;
    step;
    rst = 1'b0;
    put(0, 10, 20, 0);
    put(1, 33, 40, 1);
    req_valid = 2'b11;
    for (int g = 0; g < 4; g++) begin
      int n;
      n = 0;
      #1;
      while (req_ready == 2'b00 && n < 10) begin step; #1; n++; end
      chk("alt_grant", int'(req_ready), 1 << (g % 2));
      n = 0;
      while (!rsp_valid && n < 10) begin step; #1; n++; end
      chk("alt_id", int'(rsp_id), g % 2);
      chk("alt_sum", int'(rsp_sum), (g % 2) ? 10 : 30);
      step;
    end
    req_valid = 2'b00;
    step;
    put(0, 7, 9, 0);
    req_valid = 2'b01;
    rsp_ready = 1'b0;
    #1 chk("bp_grant", int'(req_ready), 1);
    step;
    step;
    req_valid = 2'b11;
    for (int k = 0; k < 5; k++) begin
      #1 chk("bp_valid", int'(rsp_valid), 1);
      chk("bp_sum", int'(rsp_sum), 16);
      chk("bp_ready", int'(req_ready), 0);
      step;
    end
    req_valid = 2'b01;
    rsp_ready = 1'b1;
    #1 chk("bp_valid6", int'(rsp_valid), 1);
    step;
    #1 chk("bp_next_grant", int'(req_ready), 1);
    chk("bp_cleared", int'(rsp_valid), 0);
    step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    req_valid = 2'b00;
    for (int k = 0; k < 3; k++) begin
      #1 chk("rst_busy_no_rsp", int'(rsp_valid), 0);
      step;
    end
    req_valid = 2'b11;
    #1 chk("rst_busy_grant0", int'(req_ready), 1);
    req_valid = 2'b00;
    step;
    a3[5:0] = 6'd31;
    b3[5:0] = 6'd1;
    v3 = 2'b01;
    #1 chk("lat3_ready", int'(rdy3), 1);
    step;
    v3 = 2'b00;
    for (int k = 1; k <= 3; k++) begin
      #1 chk("lat3_add_a", int'(add_a3), 31);
      chk("lat3_add_b", int'(add_b3), 1);
      chk("lat3_no_valid", int'(val3), 0);
      step;
    end
    #1 chk("lat3_valid", int'(val3), 1);
    chk("lat3_sum", int'(sum3), 32);
    chk("lat3_cout", int'(cout3), 0);
`ifdef ADDER_SCHED_OVF_EN
    chk("lat3_ovf", int'(ovf3), 1);
`endif
    step;
    #1 chk("lat3_done", int'(val3), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
